// File: rtl/dram_timing_ctrl.sv
// DRAM command timing tracker: times each command-FSM state and flags its
// completion with a one-cycle done pulse, and paces periodic refresh requests.
package dram_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ACTIVATE,
    BANK_ACTIVE,
    READ,
    WRITE,
    PRECHARGE,
    REFRESH
  } dram_state_t;
endpackage

module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned tRCD   = 14,
  parameter int unsigned tCL    = 14,
  parameter int unsigned tBURST = 4,
  parameter int unsigned tCWL   = 12,
  parameter int unsigned tWR    = 16,
  parameter int unsigned tRP    = 14,
  parameter int unsigned tRFC   = 260,
  parameter int unsigned tREFI  = 7800
) (
  input  logic        CLK,
  input  logic        RST,
  input  dram_state_t cmd_state,
  input  logic        init_done,
  output logic        tACT_done,
  output logic        tRD_done,
  output logic        tWR_done,
  output logic        tPRE_done,
  output logic        tREF_done,
  output logic        rf_req
);

  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned P_ACT   = 64'(tRCD);
  localparam longint unsigned P_RD    = 64'(tCL) + 64'(tBURST);
  localparam longint unsigned P_WR    = 64'(tCWL) + 64'(tBURST) + 64'(tWR);
  localparam longint unsigned P_PRE   = 64'(tRP);
  localparam longint unsigned P_REF   = 64'(tRFC);
  localparam longint unsigned P_REFI  = 64'(tREFI);

  // Every period must be non-zero and representable in the counter width.
  if (P_ACT < 1 || P_RD < 1 || P_WR < 1 || P_PRE < 1 || P_REF < 1 || P_REFI < 1 ||
      P_ACT > MAX_CNT || P_RD > MAX_CNT || P_WR > MAX_CNT || P_PRE > MAX_CNT ||
      P_REF > MAX_CNT || P_REFI > MAX_CNT) begin : g_bad_period
    $error("dram_timing_ctrl: a timing period is zero or exceeds 2**CNT_W-1");
  end

  // Done fires when the effective count equals period-1 (T-th cycle of a visit).
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(P_ACT - 64'd1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(P_RD - 64'd1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(P_WR - 64'd1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(P_PRE - 64'd1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(P_REF - 64'd1);
  localparam logic [CNT_W-1:0] REFI_W   = CNT_W'(P_REFI);

  dram_state_t      prev_state;
  logic [CNT_W-1:0] cnt_q, cnt_eff, cnt_next;
  logic [CNT_W-1:0] ref_q, ref_eff, ref_next;
  logic             entry, ref_entry;

  // Visit detection, effective counts and saturating next-count values.
  // A refresh entry zeroes the interval count in its own cycle, so the next
  // request lands exactly tREFI cycles after the entry.
  always_comb begin
    entry     = (cmd_state != prev_state);
    ref_entry = entry && (cmd_state == REFRESH);
    cnt_eff   = entry ? '0 : cnt_q;
    cnt_next  = (cnt_eff == '1) ? cnt_eff : cnt_eff + CNT_W'(1);
    ref_eff   = ref_entry ? '0 : ref_q;
    if (!init_done) begin
      ref_next = '0;
    end else if (ref_eff == REFI_W) begin
      ref_next = ref_eff;
    end else begin
      ref_next = ref_eff + CNT_W'(1);
    end
  end

  // Done pulses and refresh request; all forced low during reset.
  always_comb begin
    tACT_done = 1'b0;
    tRD_done  = 1'b0;
    tWR_done  = 1'b0;
    tPRE_done = 1'b0;
    tREF_done = 1'b0;
    rf_req    = 1'b0;
    if (!RST) begin
      case (cmd_state)
        ACTIVATE:  tACT_done = (cnt_eff == ACT_LAST);
        READ:      tRD_done  = (cnt_eff == RD_LAST);
        WRITE:     tWR_done  = (cnt_eff == WR_LAST);
        PRECHARGE: tPRE_done = (cnt_eff == PRE_LAST);
        REFRESH:   tREF_done = (cnt_eff == REF_LAST);
        default:   ;
      endcase
      rf_req = (ref_eff == REFI_W);
    end
  end

  // State history, command counter and refresh interval counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_state <= IDLE;
      cnt_q      <= '0;
      ref_q      <= '0;
    end else begin
      prev_state <= cmd_state;
      cnt_q      <= cnt_next;
      ref_q      <= ref_next;
    end
  end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Self-checking bench for dram_timing_ctrl (defaults, tREFI=10).
module tb_dram_timing_ctrl;
  import dram_pkg::*;

  localparam int TREFI = 10;

  logic        CLK = 1'b0;
  logic        RST;
  dram_state_t cmd_state;
  logic        init_done;
  logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req;

  dram_timing_ctrl #(.tREFI(TREFI)) dut (
    .CLK(CLK), .RST(RST), .cmd_state(cmd_state), .init_done(init_done),
    .tACT_done(tACT_done), .tRD_done(tRD_done), .tWR_done(tWR_done),
    .tPRE_done(tPRE_done), .tREF_done(tREF_done), .rf_req(rf_req)
  );

  always #5 CLK = ~CLK;

  // Bit order in both queues: {act, rd, wr, pre, ref, rf}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 1-based cycle index within a visit, cycles since refresh pacing began
  dram_state_t m_prev  = IDLE;
  int          m_vlen  = 0;
  int          m_since = 0;

  function automatic int period(input dram_state_t s);
    case (s)
      ACTIVATE:  return 14;
      READ:      return 18;
      WRITE:     return 32;
      PRECHARGE: return 14;
      REFRESH:   return 260;
      default:   return 0;
    endcase
  endfunction

  task automatic cycle(input dram_state_t s, input logic init, input logic rst);
    logic [5:0] e;
    int vlen, t;
    bit ent, rent;
    cmd_state = s;
    init_done = init;
    RST       = rst;
    ent  = (s != m_prev);
    vlen = ent ? 1 : m_vlen + 1;
    t    = period(s);
    rent = ent && (s == REFRESH);
    e    = '0;
    if (!rst) begin
      if (t != 0 && vlen == t) begin
        case (s)
          ACTIVATE:  e[5] = 1'b1;
          READ:      e[4] = 1'b1;
          WRITE:     e[3] = 1'b1;
          PRECHARGE: e[2] = 1'b1;
          REFRESH:   e[1] = 1'b1;
          default:   ;
        endcase
      end
      e[0] = (m_since >= TREFI) && !rent;
    end
    exp_q.push_back(e);
    @(negedge CLK);
    obs_q.push_back({tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req});
    @(posedge CLK);
    #1;
    if (rst) begin
      m_prev = IDLE; m_vlen = 0; m_since = 0;
    end else begin
      m_prev = s; m_vlen = vlen;
      if (!init) m_since = 0;
      else if (rent) m_since = 1;
      else m_since = m_since + 1;
    end
  endtask

  task automatic run(input dram_state_t s, input int n, input logic init);
    for (int k = 0; k < n; k++) cycle(s, init, 1'b0);
  endtask

  task automatic test_reset;
    logic [5:0] e, o;
    int i;
    for (int k = 0; k < 4; k++) cycle(ACTIVATE, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) cycle(READ, 1'b0, 1'b1);
    cycle(IDLE, 1'b0, 1'b1);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset cyc%0d: got %b want %b", i, o, e); end
      i++;
    end
  endtask

  task automatic test_activate;
    logic [5:0] e, o;
    int i, first, cnt;
    run(IDLE, 2, 1'b0);
    run(ACTIVATE, 20, 1'b0);
    i = 0; first = -1; cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL activate cyc%0d: got %b want %b", i, o, e); end
      if (o[5]) begin cnt++; if (first < 0) first = i; end
      i++;
    end
    n_cmp++;
    if (first !== 2 + 13 || cnt !== 1) begin
      n_bad++; $display("FAIL act_pulse: got idx %0d count %0d want idx 15 count 1", first, cnt);
    end
  endtask

  task automatic test_write_read;
    logic [5:0] e, o;
    int i, fw, fr, cw, cr;
    run(IDLE, 1, 1'b0);
    run(WRITE, 40, 1'b0);
    run(READ, 20, 1'b0);
    i = 0; fw = -1; fr = -1; cw = 0; cr = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL write_read cyc%0d: got %b want %b", i, o, e); end
      if (o[3]) begin cw++; if (fw < 0) fw = i; end
      if (o[4]) begin cr++; if (fr < 0) fr = i; end
      i++;
    end
    n_cmp++;
    if (fw !== 1 + 31 || cw !== 1) begin
      n_bad++; $display("FAIL wr_pulse: got idx %0d count %0d want idx 32 count 1", fw, cw);
    end
    n_cmp++;
    if (fr !== 41 + 17 || cr !== 1) begin
      n_bad++; $display("FAIL rd_pulse: got idx %0d count %0d want idx 58 count 1", fr, cr);
    end
  endtask

  task automatic test_precharge_abort;
    logic [5:0] e, o;
    int i, first, cnt;
    run(IDLE, 1, 1'b0);
    run(PRECHARGE, 5, 1'b0);
    run(IDLE, 2, 1'b0);
    run(PRECHARGE, 16, 1'b0);
    i = 0; first = -1; cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL precharge cyc%0d: got %b want %b", i, o, e); end
      if (o[2]) begin cnt++; if (first < 0) first = i; end
      i++;
    end
    n_cmp++;
    if (first !== 8 + 13 || cnt !== 1) begin
      n_bad++; $display("FAIL pre_pulse: got idx %0d count %0d want idx 21 count 1", first, cnt);
    end
  endtask

  task automatic test_reset_midcount;
    logic [5:0] e, o;
    int i, first, cnt;
    run(IDLE, 2, 1'b0);
    run(READ, 6, 1'b0);
    cycle(READ, 1'b0, 1'b1);
    run(READ, 25, 1'b0);
    i = 0; first = -1; cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_mid cyc%0d: got %b want %b", i, o, e); end
      if (o[4]) begin cnt++; if (first < 0) first = i; end
      i++;
    end
    n_cmp++;
    if (first !== 9 + 17 || cnt !== 1) begin
      n_bad++; $display("FAIL rd_after_reset: got idx %0d count %0d want idx 26 count 1", first, cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] e, o;
    int i, first, second, cnt;
    run(IDLE, 1, 1'b0);
    run(ACTIVATE, 30, 1'b0);
    run(IDLE, 1, 1'b0);
    run(ACTIVATE, 14, 1'b0);
    i = 0; first = -1; second = -1; cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL back_to_back cyc%0d: got %b want %b", i, o, e); end
      if (o[5]) begin
        cnt++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      i++;
    end
    n_cmp++;
    if (first !== 14 || second !== 45 || cnt !== 2) begin
      n_bad++;
      $display("FAIL act_b2b: got idx %0d,%0d count %0d want idx 14,45 count 2", first, second, cnt);
    end
  endtask

  task automatic test_refresh;
    logic [5:0] e, o;
    int i, f1, f2, fref, cref;
    logic rf_at_entry;
    run(IDLE, 25, 1'b1);
    run(REFRESH, 270, 1'b1);
    run(IDLE, 3, 1'b1);
    i = 0; f1 = -1; f2 = -1; fref = -1; cref = 0; rf_at_entry = 1'bx;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL refresh cyc%0d: got %b want %b", i, o, e); end
      if (o[0] && f1 < 0) f1 = i;
      if (o[0] && i > 25 && f2 < 0) f2 = i;
      if (i == 25) rf_at_entry = o[0];
      if (o[1]) begin cref++; if (fref < 0) fref = i; end
      i++;
    end
    n_cmp++;
    if (f1 !== 10) begin n_bad++; $display("FAIL rf_first: got idx %0d want 10", f1); end
    n_cmp++;
    if (rf_at_entry !== 1'b0) begin n_bad++; $display("FAIL rf_at_entry: got %b want 0", rf_at_entry); end
    n_cmp++;
    if (f2 !== 35) begin n_bad++; $display("FAIL rf_after_ref: got idx %0d want 35", f2); end
    n_cmp++;
    if (fref !== 25 + 259 || cref !== 1) begin
      n_bad++; $display("FAIL ref_pulse: got idx %0d count %0d want idx 284 count 1", fref, cref);
    end
  endtask

  task automatic test_refresh_coincide;
    logic [5:0] e, o;
    int i, first;
    run(IDLE, 2, 1'b0);
    run(IDLE, 10, 1'b1);
    run(REFRESH, 12, 1'b1);
    run(IDLE, 2, 1'b0);
    i = 0; first = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL coincide cyc%0d: got %b want %b", i, o, e); end
      if (o[0] && i >= 2 && first < 0) first = i;
      i++;
    end
    n_cmp++;
    if (first !== 2 + 20) begin n_bad++; $display("FAIL rf_coincide: got idx %0d want 22", first); end
  endtask

  initial begin
    RST = 1'b1; cmd_state = IDLE; init_done = 1'b0;
    test_reset();
    test_activate();
    test_write_read();
    test_precharge_abort();
    test_reset_midcount();
    test_back_to_back();
    test_refresh();
    test_refresh_coincide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
